// File: rtl/cyc_24_seq_group_detect_if.sv
// Sample-in / detection-result-out bundle for the length-12 sequence group detector.
// The master drives the phase samples and the downstream ready; the slave returns the result.
interface cyc_24_seq_group_detect_if #(
  parameter int PHASE_W = 5
);
  logic               i_valid;
  logic               o_ready;
  logic [PHASE_W-1:0] i_phase;
  logic               o_valid;
  logic               i_ready;
  logic [4:0]         o_u;
  logic [3:0]         o_match_cnt;
  logic               o_detected;

  modport master (
    output i_valid, i_phase, i_ready,
    input  o_ready, o_valid, o_u, o_match_cnt, o_detected
  );

  modport slave (
    input  i_valid, i_phase, i_ready,
    output o_ready, o_valid, o_u, o_match_cnt, o_detected
  );
endinterface

// File: rtl/cyc_24_seq_group_detect.sv
// Slices 12 received phases to varphi codes, then scores all 30 length-12 base-sequence rows
// one (u,n) pair per cycle and reports the best group; result valid 362 edges after the 12th sample.
module cyc_24_seq_group_detect #(
  parameter int PHASE_W  = 5,
  parameter int MATCH_TH = 10
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  cyc_24_seq_group_detect_if.slave io_bus
);

  typedef enum logic [1:0] {S_COLLECT, S_SEARCH, S_FINAL, S_DONE} state_t;

  localparam int PHI [30][12] = '{
    '{-3,  1, -3, -3, -3,  3, -3, -1,  1,  1,  1, -3},
    '{-3,  3,  1, -3,  1,  3, -1, -1,  1,  3,  3,  3},
    '{-3,  3,  3,  1, -3,  3, -1,  1,  3, -3,  3, -3},
    '{-3, -3, -1,  3,  3,  3, -3,  3, -3,  1, -1, -3},
    '{-3, -1, -1,  1,  3,  1,  1, -1,  1, -1, -3,  1},
    '{-3, -3,  3,  1, -3, -3, -3, -1,  3, -1,  1,  3},
    '{ 1, -1,  3, -1, -1, -1, -3, -1,  1,  1,  1, -3},
    '{-1, -3,  3, -1, -3, -3, -3, -1,  1, -1,  1, -3},
    '{-3, -1,  3,  1, -3, -1, -3,  3,  1,  3,  3,  1},
    '{-3, -1, -1, -3, -3, -1, -3,  3,  1,  3, -1, -3},
    '{-3,  3, -3,  3,  3, -3, -1, -1,  3,  3,  1, -3},
    '{-3, -1, -3, -1, -1, -3,  3,  3, -1, -1,  1, -3},
    '{-3, -1,  3, -3, -3, -1, -3,  1, -1, -3,  3,  3},
    '{-3,  1, -1, -1,  3,  3, -3, -1, -1, -3, -1, -3},
    '{ 1,  3, -3,  1,  3,  3,  3,  1, -1,  1, -1,  3},
    '{-3,  1,  3, -1, -1, -3, -3, -1, -1,  3,  1, -3},
    '{-1, -1, -1, -1,  1, -3, -1,  3,  3, -1, -3,  1},
    '{-1,  1,  1, -1,  1,  3,  3, -1, -1, -3,  1, -3},
    '{-3,  1,  3,  3, -1, -1, -3,  3,  3, -3,  3, -3},
    '{-3, -3,  3, -3, -1,  3,  3,  3, -1, -3,  1, -3},
    '{ 3,  1,  3,  1,  3, -3, -1,  1,  3,  1, -1, -3},
    '{-3,  3,  1,  3, -3,  1,  1,  1,  1,  3, -3,  3},
    '{-3,  3,  3,  3, -1, -3, -3, -1, -3,  1,  3, -3},
    '{ 3, -1, -3,  3, -3, -1,  3,  3,  3, -3, -1, -3},
    '{-3, -1,  1, -3,  1,  3,  3,  3, -1, -3,  3,  3},
    '{-3,  3,  1, -1,  3,  3, -3,  1, -1,  1, -1,  1},
    '{-1,  1,  3, -3,  1, -1,  1, -1, -1, -3,  1, -1},
    '{-3, -3,  3,  3,  3, -3, -1,  1, -3,  3,  1, -3},
    '{ 1, -1,  3,  1,  1, -1, -1, -1,  1,  3, -3,  1},
    '{-3,  3, -3,  3, -3, -3,  3, -1, -1,  1,  3, -3}
  };

  function automatic logic [1:0] f_enc(input int v);
    case (v)
      1:       f_enc = 2'b00;
      3:       f_enc = 2'b01;
      -3:      f_enc = 2'b10;
      default: f_enc = 2'b11;
    endcase
  endfunction

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_buf [12];
  logic [3:0]         r_n;
  logic [4:0]         r_u;
  logic [3:0]         r_cnt;
  logic [4:0]         r_best_u;
  logic [3:0]         r_best_cnt;
  logic               r_ready, r_valid;
  logic [4:0]         r_o_u;
  logic [3:0]         r_o_cnt;
  logic               r_o_det;

  logic [PHASE_W-1:0] w_p;
  logic [1:0]         w_code;
  logic               w_accept, w_hit, w_last_n, w_last_u;
  logic [3:0]         w_cnt_sum;
  logic               w_store, w_search, w_final, w_release;

  // Inputs 24..31 alias onto 0..7 before quadrant slicing.
  always_comb begin
    w_p = io_bus.i_phase;
    if (io_bus.i_phase >= PHASE_W'(24)) w_p = io_bus.i_phase - PHASE_W'(24);
    if (w_p < PHASE_W'(6))       w_code = 2'b00;
    else if (w_p < PHASE_W'(12)) w_code = 2'b01;
    else if (w_p < PHASE_W'(18)) w_code = 2'b10;
    else                         w_code = 2'b11;
  end

  assign w_accept  = io_bus.i_valid && r_ready;
  assign w_hit     = (r_buf[r_n] == f_enc(PHI[r_u][r_n]));
  assign w_cnt_sum = r_cnt + 4'(w_hit);
  assign w_last_n  = (r_n == 4'd11);
  assign w_last_u  = (r_u == 5'd29);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_COLLECT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_accept && w_last_n)       w_state_nxt = S_SEARCH;
      S_SEARCH:  if (w_last_n && w_last_u)       w_state_nxt = S_FINAL;
      S_FINAL:                                   w_state_nxt = S_DONE;
      S_DONE:    if (r_valid && io_bus.i_ready)  w_state_nxt = S_COLLECT;
      default:                                   w_state_nxt = S_COLLECT;
    endcase
  end

  always_comb begin
    w_store   = (r_state == S_COLLECT) && w_accept;
    w_search  = (r_state == S_SEARCH);
    w_final   = (r_state == S_FINAL);
    w_release = (r_state == S_DONE) && r_valid && io_bus.i_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 12; i++) r_buf[i] <= 2'b00;
      r_n        <= '0;
      r_u        <= '0;
      r_cnt      <= '0;
      r_best_u   <= '0;
      r_best_cnt <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_o_u      <= '0;
      r_o_cnt    <= '0;
      r_o_det    <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_COLLECT);
      // Valid trails entry to DONE by one edge, so the first DONE cycle ignores i_ready.
      r_valid <= (r_state == S_DONE) && !w_release;
      if (w_store) begin
        r_buf[r_n] <= w_code;
        if (w_last_n) begin
          r_n        <= '0;
          r_u        <= '0;
          r_cnt      <= '0;
          r_best_u   <= '0;
          r_best_cnt <= '0;
        end else begin
          r_n <= r_n + 4'd1;
        end
      end
      if (w_search) begin
        if (w_last_n) begin
          r_n   <= '0;
          r_cnt <= '0;
          if (w_cnt_sum > r_best_cnt) begin
            r_best_u   <= r_u;
            r_best_cnt <= w_cnt_sum;
          end
          if (!w_last_u) r_u <= r_u + 5'd1;
        end else begin
          r_n   <= r_n + 4'd1;
          r_cnt <= w_cnt_sum;
        end
      end
      if (w_final) begin
        r_o_u   <= r_best_u;
        r_o_cnt <= r_best_cnt;
        r_o_det <= (r_best_cnt >= 4'(MATCH_TH));
      end
    end
  end

  assign io_bus.o_ready     = r_ready;
  assign io_bus.o_valid     = r_valid;
  assign io_bus.o_u         = r_o_u;
  assign io_bus.o_match_cnt = r_o_cnt;
  assign io_bus.o_detected  = r_o_det;

endmodule
